// File: rtl/exc_int_sequencer.sv
// Exception / interrupt / ERET sequencer around CP0.
// Conditions the device interrupt lines into the HWInt vector, picks the
// M-stage victim when CP0 requests entry, and drives flush, handler
// redirect and EXL set/clear controls toward the pipeline and CP0.
module exc_int_sequencer #(
   parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
   parameter logic [5:0]  EDGE_MASK   = 6'b000000,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned WAIT_MAX    = 15,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  dev_irq,
   input  logic        pend_clr_we,
   input  logic [5:0]  pend_clr_mask,
   output logic [5:0]  hwint,
   input  logic        cp0_int_req,
   input  logic [29:0] cp0_epc,
   input  logic        m_valid,
   input  logic [29:0] m_pc,
   input  logic        m_bd,
   input  logic        m_eret,
   input  logic [4:0]  m_exccode,
   output logic        exl_set,
   output logic        exl_clr,
   output logic [29:0] cp0_pc,
   output logic        cp0_bd,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [15:0] take_count
);

   localparam int unsigned SS = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
   localparam int unsigned WW = $clog2(WAIT_MAX + 2);
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 2);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT_M = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   logic [SS-1:0][5:0] sync_q;
   logic [5:0]         sync_prev;
   logic [5:0]         pend;
   logic [5:0]         pend_next;
   logic [5:0]         hwint_q;
   logic [1:0]         state, state_d;
   logic [WW-1:0]      wait_cnt, wait_d;
   logic [HW-1:0]      hold_cnt, hold_d;
   logic [29:0]        last_pc;
   logic [15:0]        take_cnt_q;
   logic               do_take, do_eret, timeout, act;

   // Edge-pending update; a fresh rising edge wins over a coincident clear.
   always_comb begin
      pend_next = ((pend & ~(pend_clr_we ? pend_clr_mask : 6'b000000))
                   | (sync_q[SS-1] & ~sync_prev)) & EDGE_MASK;
   end

   // Synchronizer chain, edge-pending bits and the registered HWInt vector.
   // hwint is loaded from pend_next so edge and level sources share latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '0;
         sync_prev <= '0;
         pend      <= '0;
         hwint_q   <= '0;
      end else begin
         sync_q[0] <= dev_irq;
         for (int unsigned i = 1; i < SS; i++) sync_q[i] <= sync_q[i-1];
         sync_prev <= sync_q[SS-1];
         pend      <= pend_next;
         hwint_q   <= pend_next | (~EDGE_MASK & sync_q[SS-1]);
      end
   end

   // Take / ERET decision and next-state logic.
   always_comb begin
      do_take = 1'b0;
      do_eret = 1'b0;
      timeout = 1'b0;
      state_d = state;
      wait_d  = wait_cnt;
      hold_d  = hold_cnt;
      case (state)
         ST_IDLE: begin
            if (cp0_int_req) begin
               if (m_valid || m_exccode != 5'd0) begin
                  do_take = 1'b1;
               end else begin
                  state_d = ST_WAIT_M;
                  wait_d  = '0;
               end
            end else if (m_valid && m_eret) begin
               do_eret = 1'b1;
            end
         end
         ST_WAIT_M: begin
            if (m_valid) begin
               do_take = 1'b1;
            end else if (!cp0_int_req) begin
               state_d = ST_IDLE;
            end else if (wait_cnt == WW'(WAIT_MAX)) begin
               do_take = 1'b1;
               timeout = 1'b1;
            end else begin
               wait_d = wait_cnt + WW'(1);
            end
         end
         ST_HOLD: begin
            if (HOLD_CYCLES <= 1 || hold_cnt == HW'(HOLD_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               hold_d = hold_cnt + HW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A zero-length lockout skips HOLD so back-to-back takes are possible.
      if (do_take || do_eret) begin
         state_d = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
         hold_d  = '0;
      end
   end

   // FSM state, counters and the last valid M-stage PC.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         hold_cnt   <= '0;
         last_pc    <= '0;
         take_cnt_q <= '0;
      end else begin
         state    <= state_d;
         wait_cnt <= wait_d;
         hold_cnt <= hold_d;
         if (m_valid) last_pc <= m_pc;
         if (do_take) take_cnt_q <= take_cnt_q + 16'd1;
      end
   end

   // Mealy outputs, all held at zero while reset is asserted.
   always_comb begin
      act            = !reset;
      flush          = act && (do_take || do_eret);
      redirect_valid = act && (do_take || do_eret);
      exl_set        = act && do_take;
      exl_clr        = act && do_eret;
      cp0_pc         = '0;
      cp0_bd         = 1'b0;
      redirect_pc    = '0;
      if (act && do_take) begin
         cp0_pc      = timeout ? last_pc + 30'd1 : m_pc;
         cp0_bd      = !timeout && m_bd;
         redirect_pc = HANDLER_PC;
      end else if (act && do_eret) begin
         redirect_pc = {cp0_epc, 2'b00};
      end
      hwint      = act ? hwint_q : 6'b000000;
      take_count = act ? take_cnt_q : 16'd0;
   end

endmodule

// File: tb/tb_exc_int_sequencer.sv
// Self-checking bench for exc_int_sequencer: stimulus tables per scenario,
// expected outputs queued when a step is driven and compared when sampled.
module tb_exc_int_sequencer;

   typedef struct packed {
      logic        flush;
      logic        rv;
      logic        xset;
      logic        xclr;
      logic        bd;
      logic [29:0] pc;
      logic [31:0] rpc;
      logic [5:0]  hw;
   } out_t;

   typedef struct {
      logic        rst, req, mv, bd, eret, clr_we;
      logic [29:0] pc, epc;
      logic [4:0]  exc;
      logic [5:0]  dev, clr_mask;
      out_t        exp;
   } st_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  dev_irq, pend_clr_mask, hwint, hwint2;
   logic        pend_clr_we, cp0_int_req, m_valid, m_bd, m_eret;
   logic [29:0] cp0_epc, m_pc, cp0_pc, cp0_pc2;
   logic [4:0]  m_exccode;
   logic        exl_set, exl_clr, cp0_bd, flush, redirect_valid;
   logic [31:0] redirect_pc, redirect_pc2;
   logic [15:0] take_count, take_count2;
   logic        req2, mv2, exl_set2, exl_clr2, cp0_bd2, flush2, rv2;
   out_t        obs;
   out_t        exp_q[$];
   out_t        e;
   int          checks = 0;
   int          failures = 0;

   assign obs = {flush, redirect_valid, exl_set, exl_clr, cp0_bd, cp0_pc, redirect_pc, hwint};

   always #5 clk = ~clk;

   exc_int_sequencer #(
      .HANDLER_PC(32'h0000_4180), .EDGE_MASK(6'b000001), .SYNC_STAGES(2),
      .WAIT_MAX(15), .HOLD_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset), .dev_irq(dev_irq), .pend_clr_we(pend_clr_we),
      .pend_clr_mask(pend_clr_mask), .hwint(hwint), .cp0_int_req(cp0_int_req),
      .cp0_epc(cp0_epc), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd),
      .m_eret(m_eret), .m_exccode(m_exccode), .exl_set(exl_set), .exl_clr(exl_clr),
      .cp0_pc(cp0_pc), .cp0_bd(cp0_bd), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .take_count(take_count)
   );

   // Zero lockout so a take can fire every cycle for the counter wrap run.
   exc_int_sequencer #(
      .HANDLER_PC(32'h0000_4180), .EDGE_MASK(6'b000000), .SYNC_STAGES(2),
      .WAIT_MAX(15), .HOLD_CYCLES(0)
   ) dut2 (
      .clk(clk), .reset(reset), .dev_irq(dev_irq), .pend_clr_we(pend_clr_we),
      .pend_clr_mask(pend_clr_mask), .hwint(hwint2), .cp0_int_req(req2),
      .cp0_epc(cp0_epc), .m_valid(mv2), .m_pc(m_pc), .m_bd(m_bd),
      .m_eret(m_eret), .m_exccode(m_exccode), .exl_set(exl_set2), .exl_clr(exl_clr2),
      .cp0_pc(cp0_pc2), .cp0_bd(cp0_bd2), .flush(flush2), .redirect_valid(rv2),
      .redirect_pc(redirect_pc2), .take_count(take_count2)
   );

   function automatic out_t o_take(input logic [29:0] pc, input logic bd);
      out_t o = '0;
      o.flush = 1'b1; o.rv = 1'b1; o.xset = 1'b1; o.bd = bd; o.pc = pc;
      o.rpc = 32'h0000_4180;
      return o;
   endfunction

   function automatic out_t o_eret(input logic [31:0] rpc);
      out_t o = '0;
      o.flush = 1'b1; o.rv = 1'b1; o.xclr = 1'b1; o.rpc = rpc;
      return o;
   endfunction

   function automatic st_t f(input logic rst, req, mv, input logic [29:0] pc,
                             input logic bd, eret, input logic [4:0] exc,
                             input logic [29:0] epc, input out_t ex);
      st_t s;
      s.rst = rst; s.req = req; s.mv = mv; s.pc = pc; s.bd = bd; s.eret = eret;
      s.exc = exc; s.epc = epc; s.dev = '0; s.clr_we = 1'b0; s.clr_mask = '0;
      s.exp = ex;
      return s;
   endfunction

   function automatic st_t h(input logic [5:0] dev, input logic clr, input logic [5:0] hw);
      st_t s = f(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      s.dev = dev; s.clr_we = clr; s.clr_mask = 6'b000001; s.exp.hw = hw;
      return s;
   endfunction

   task automatic apply(input st_t s);
      reset = s.rst; cp0_int_req = s.req; m_valid = s.mv; m_pc = s.pc; m_bd = s.bd;
      m_eret = s.eret; m_exccode = s.exc; cp0_epc = s.epc; dev_irq = s.dev;
      pend_clr_we = s.clr_we; pend_clr_mask = s.clr_mask;
      exp_q.push_back(s.exp);
   endtask

   task automatic test_reset();
      st_t tab[$];
      st_t s;
      s = f(1'b1, 1'b1, 1'b1, 30'h0C01, 1'b1, 1'b1, 5'h05, 30'h0C10, '0);
      s.dev = 6'h3F;
      tab.push_back(s);
      tab.push_back(s);
      for (int i = 0; i < tab.size(); i++) begin
         @(negedge clk); apply(tab[i]); #1;
         e = exp_q.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL reset step=%0d got=%h exp=%h", i, obs, e); end
      end
      checks++;
      if (take_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", take_count); end
   endtask

   task automatic test_hwint();
      st_t tab[$];
      tab.push_back(h(6'b001001, 1'b0, 6'b000000));
      tab.push_back(h(6'b001000, 1'b0, 6'b000000));
      tab.push_back(h(6'b001000, 1'b0, 6'b000000));
      tab.push_back(h(6'b001000, 1'b0, 6'b001001));
      tab.push_back(h(6'b000000, 1'b0, 6'b001001));
      tab.push_back(h(6'b000000, 1'b0, 6'b001001));
      tab.push_back(h(6'b000000, 1'b1, 6'b001001));
      tab.push_back(h(6'b000000, 1'b0, 6'b000000));
      tab.push_back(h(6'b000001, 1'b0, 6'b000000));
      tab.push_back(h(6'b000000, 1'b0, 6'b000000));
      tab.push_back(h(6'b000000, 1'b1, 6'b000000));
      tab.push_back(h(6'b000000, 1'b0, 6'b000001));
      tab.push_back(h(6'b000000, 1'b0, 6'b000001));
      tab.push_back(h(6'b000000, 1'b1, 6'b000001));
      tab.push_back(h(6'b000000, 1'b0, 6'b000000));
      for (int i = 0; i < tab.size(); i++) begin
         @(negedge clk); apply(tab[i]); #1;
         e = exp_q.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL hwint step=%0d got=%h exp=%h", i, obs, e); end
      end
   endtask

   task automatic test_take();
      st_t tab[$];
      tab.push_back(f(0, 1, 1, 30'h0C01, 1, 0, 5'h00, 30'h0, o_take(30'h0C01, 1'b1)));
      tab.push_back(f(0, 1, 1, 30'h0C02, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 1, 1, 30'h0C03, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 1, 0, 30'h0D00, 0, 0, 5'h0A, 30'h0, o_take(30'h0D00, 1'b0)));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      checks++;
      if (take_count !== 16'd0) begin failures++; $display("FAIL take_count_pre got=%0d exp=0", take_count); end
      for (int i = 0; i < tab.size(); i++) begin
         @(negedge clk); apply(tab[i]); #1;
         e = exp_q.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL take step=%0d got=%h exp=%h", i, obs, e); end
      end
      checks++;
      if (take_count !== 16'd2) begin failures++; $display("FAIL take_count got=%0d exp=2", take_count); end
   endtask

   task automatic test_wait_m();
      st_t tab[$];
      for (int k = 0; k < 3; k++) tab.push_back(f(0, 1, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 1, 1, 30'h0C08, 0, 0, 5'h00, 30'h0, o_take(30'h0C08, 1'b0)));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 1, 30'h0C04, 0, 0, 5'h00, 30'h0, '0));
      for (int k = 0; k < 16; k++) tab.push_back(f(0, 1, 0, 30'h3FFF_FFFF, 1, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 1, 0, 30'h3FFF_FFFF, 1, 0, 5'h00, 30'h0, o_take(30'h0C05, 1'b0)));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      for (int i = 0; i < tab.size(); i++) begin
         @(negedge clk); apply(tab[i]); #1;
         e = exp_q.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL wait_m step=%0d got=%h exp=%h", i, obs, e); end
      end
      checks++;
      if (take_count !== 16'd4) begin failures++; $display("FAIL wait_count got=%0d exp=4", take_count); end
   endtask

   task automatic test_eret();
      st_t tab[$];
      tab.push_back(f(0, 0, 1, 30'h0, 0, 1, 5'h00, 30'h0C10, o_eret(32'h0000_3040)));
      tab.push_back(f(0, 0, 1, 30'h0, 0, 1, 5'h00, 30'h0C10, '0));
      tab.push_back(f(0, 1, 1, 30'h0, 0, 1, 5'h00, 30'h0C10, '0));
      tab.push_back(f(0, 1, 1, 30'h0C11, 0, 1, 5'h00, 30'h0C10, o_take(30'h0C11, 1'b0)));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 1, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 1, 30'h0, 0, 1, 5'h00, 30'h0C20, o_eret(32'h0000_3080)));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      for (int i = 0; i < tab.size(); i++) begin
         @(negedge clk); apply(tab[i]); #1;
         e = exp_q.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL eret step=%0d got=%h exp=%h", i, obs, e); end
      end
      checks++;
      if (take_count !== 16'd5) begin failures++; $display("FAIL eret_count got=%0d exp=5", take_count); end
   endtask

   task automatic test_reset_wait();
      st_t tab[$];
      for (int k = 0; k < 3; k++) tab.push_back(f(0, 1, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(1, 1, 1, 30'h0C09, 1, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 1, 30'h0, 0, 1, 5'h00, 30'h0C30, o_eret(32'h0000_30C0)));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      tab.push_back(f(0, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      for (int i = 0; i < tab.size(); i++) begin
         @(negedge clk); apply(tab[i]); #1;
         e = exp_q.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL reset_wait step=%0d got=%h exp=%h", i, obs, e); end
      end
      checks++;
      if (take_count !== 16'd0) begin failures++; $display("FAIL reset_wait_count got=%0d exp=0", take_count); end
   endtask

   task automatic test_take_count_wrap();
      @(negedge clk);
      apply(f(1, 0, 0, 30'h0, 0, 0, 5'h00, 30'h0, '0));
      void'(exp_q.pop_front());
      req2 = 1'b0; mv2 = 1'b0;
      @(negedge clk);
      apply(f(0, 0, 0, 30'h0123, 0, 0, 5'h00, 30'h0, '0));
      void'(exp_q.pop_front());
      req2 = 1'b1; mv2 = 1'b1;
      #1;
      checks++;
      if (flush2 !== 1'b1 || exl_set2 !== 1'b1 || cp0_pc2 !== 30'h0123 || take_count2 !== 16'd0) begin
         failures++;
         $display("FAIL wrap_first got flush=%b set=%b pc=%h cnt=%0d exp 1 1 0123 0", flush2, exl_set2, cp0_pc2, take_count2);
      end
      repeat (65535) @(negedge clk);
      #1;
      checks++;
      if (take_count2 !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", take_count2); end
      @(negedge clk); #1;
      checks++;
      if (take_count2 !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", take_count2); end
      req2 = 1'b0; mv2 = 1'b0;
   endtask

   initial begin
      reset = 1'b1; dev_irq = '0; pend_clr_we = 1'b0; pend_clr_mask = '0;
      cp0_int_req = 1'b0; cp0_epc = '0; m_valid = 1'b0; m_pc = '0; m_bd = 1'b0;
      m_eret = 1'b0; m_exccode = '0; req2 = 1'b0; mv2 = 1'b0;
      test_reset();
      test_hwint();
      test_take();
      test_wait_m();
      test_eret();
      test_reset_wait();
      test_take_count_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exc_int_sequencer.md
Name: exc_int_sequencer

Overview:
Sequences the pipeline response to exceptions, interrupts and ERET around the CP0 register block. It conditions six device interrupt lines into the HWInt vector that CP0 consumes. When CP0 raises its interrupt request, the block chooses the victim instruction at the M stage and drives the flush, the handler redirect and the EXL set/clear controls. It sits between the M-stage pipeline register, CP0 and the PC-select mux in the F stage.

Parameters:
HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address
EDGE_MASK, 6'b000000, per-source mode: 1 = rising-edge sticky, 0 = level
SYNC_STAGES, 2, flip-flop depth of the dev_irq synchronizer (minimum 1)
WAIT_MAX, 15, maximum cycles to wait for a valid M-stage instruction
HOLD_CYCLES, 2, lockout cycles after a take before another take is allowed

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dev_irq  in  6  raw device interrupt lines, asynchronous
pend_clr_we  in  1  software clear strobe for edge-pending bits
pend_clr_mask  in  6  bits to clear when pend_clr_we is high
hwint  out  6  conditioned interrupt vector to CP0
cp0_int_req  in  1  CP0 request (exception or enabled interrupt)
cp0_epc  in  30  EPC[31:2] from CP0
m_valid  in  1  M stage holds a real instruction, not a bubble
m_pc  in  30  M-stage PC[31:2]
m_bd  in  1  M-stage instruction is in a delay slot
m_eret  in  1  M-stage instruction is ERET
m_exccode  in  5  synchronous exception code carried to M; 0 = none
exl_set  out  1  pulse: CP0 enters exception level
exl_clr  out  1  pulse: CP0 leaves exception level
cp0_pc  out  30  victim PC[31:2] for CP0 EPC capture
cp0_bd  out  1  victim delay-slot flag for CP0
flush  out  1  pulse: clear the F/D/E/M pipeline registers
redirect_valid  out  1  pulse: PC mux takes redirect_pc
redirect_pc  out  32  next-fetch address
take_count  out  16  number of exception entries taken, wraps modulo 2^16

Behaviour:
- Reset: all FSM, pending, synchronizer and counter state goes to 0; state = IDLE. While reset is high, every output is forced to 0.
- Interrupt conditioning:
  - Each dev_irq bit passes through SYNC_STAGES flip-flops.
  - Edge bits: pend is set on a 0->1 transition of the synchronized value.
  - pend_clr_we clears the masked pend bits. A new edge in the same cycle wins, so the bit stays 1.
  - hwint[i] = EDGE_MASK[i] ? pend[i] : sync[i]. This is registered, so a raw level reaches hwint in SYNC_STAGES+1 cycles.
- FSM states: IDLE, WAIT_M, HOLD. The take and eret outputs are Mealy, valid in the same cycle as the decision, so CP0 samples them at the next clk edge.
- Take conditions:
  - IDLE, cp0_int_req=1 and (m_valid=1 or m_exccode!=0) -> TAKE.
  - IDLE, cp0_int_req=1 and m_valid=0 -> WAIT_M; wait_cnt <= 0; no outputs.
  - WAIT_M, m_valid=1 -> TAKE.
  - WAIT_M, cp0_int_req=0 -> IDLE with no outputs (request withdrawn).
  - WAIT_M, wait_cnt = WAIT_MAX -> TAKE with cp0_pc = last_pc + 1 and cp0_bd = 0.
  - Otherwise in WAIT_M, wait_cnt increments.
- TAKE outputs (one cycle):
  - flush=1, redirect_valid=1, redirect_pc=HANDLER_PC, exl_set=1.
  - cp0_pc = m_pc, cp0_bd = m_bd (except the timeout case above).
  - take_count increments.
  - Next state = HOLD with hold_cnt = 0.
- HOLD: ignores cp0_int_req and m_eret. Returns to IDLE after HOLD_CYCLES cycles.
- ERET: in IDLE with cp0_int_req=0, m_valid=1 and m_eret=1:
  - flush=1, redirect_valid=1, redirect_pc = {cp0_epc, 2'b00}, exl_clr=1 for one cycle.
  - Next state = HOLD.
- Priority: a take beats an ERET in the same cycle; exl_set and exl_clr are never both 1.
- last_pc: updated to m_pc every cycle that m_valid=1, in any state.
- Idle outputs: outside a take or ERET cycle, all pulse outputs are 0. cp0_pc, cp0_bd and redirect_pc are 0 unless their accompanying pulse is 1.
- Reset mid-WAIT_M or mid-HOLD: returns to IDLE immediately; no pulse is emitted.
- take_count wraps from 16'hFFFF to 0.

Test Plan:
- Edge source 0 (EDGE_MASK=6'b000001), dev_irq[0] pulsed for 1 cycle -> hwint[0]=1 after 3 cycles and stays set. pend_clr_we with mask 6'b000001 -> hwint[0]=0 next cycle. Clear coincident with a new edge -> stays 1.
- cp0_int_req=1 with m_valid=1, m_pc=30'h0C01, m_bd=1 -> same cycle: flush=1, redirect_pc=32'h0000_4180, exl_set=1, cp0_pc=30'h0C01, cp0_bd=1; take_count 0->1; no take for the next 2 cycles even though req stays 1.
- cp0_int_req=1 with m_valid=0 for 3 cycles, then m_valid=1 with m_pc=30'h0C08 -> the take fires in that cycle with cp0_pc=30'h0C08. A repeat run with m_valid=0 for 16 cycles and last_pc=30'h0C04 -> take at wait_cnt=15 with cp0_pc=30'h0C05, cp0_bd=0.
- m_eret=1, m_valid=1, cp0_epc=30'h0C10 -> flush=1, redirect_pc=32'h0000_3040, exl_clr=1. ERET coincident with cp0_int_req=1 -> exl_set only, redirect to 32'h0000_4180.
- Reset asserted while in WAIT_M -> all outputs 0, next cycle in IDLE. take_count preloaded by 65536 takes reads 0.
